// File: rtl/gcd_control.sv
// Sequencing FSM for the 16-bit Euclidean GCD datapath (Moore, outputs decoded from state).
// Optional MOD_WAIT watchdog enabled by defining GCD_CTRL_TIMEOUT_EN.
module gcd_control #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       valid_i,
   input  logic       modulo_ready_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o,
   output logic [7:0] iter_o,
   output logic [2:0] alu_mode_o,
   output logic       modulo_start_o,
   output logic       zahl1_to_alu_a_o,
   output logic       zahl2_to_alu_b_o,
   output logic       wren_initial_o,
   output logic       wren_zw_gross_o,
   output logic       wren_zw_klein_o,
   output logic       wren_zw_in_zahlen_o,
   output logic       wren_erg_modulo_o,
   output logic       wren_zahl_o,
   output logic       wren_to_new_numbers_o,
   output logic       check_for_termination_o
);

   localparam logic [2:0] MODE_MAX = 3'd1;
   localparam logic [2:0] MODE_MIN = 3'd2;
   localparam logic [2:0] MODE_MOD = 3'd3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MAX,
      ST_WB_MAX,
      ST_MIN,
      ST_WB_MIN,
      ST_SWAP,
      ST_MOD_START,
      ST_MOD_WAIT,
      ST_MOD_CAP,
      ST_WB_MOD,
      ST_CHECK,
      ST_NEXT,
`ifdef GCD_CTRL_TIMEOUT_EN
      ST_DONE,
      ST_ERROR
`else
      ST_DONE
`endif
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] iter_q;

`ifdef GCD_CTRL_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic       wait_expired;

   assign wait_expired = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni)                     wait_cnt <= '0;
      else if (state == ST_MOD_START)  wait_cnt <= '0;
      else if (state == ST_MOD_WAIT)   wait_cnt <= wait_cnt + 8'd1;
   end
`endif

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Iteration count survives DONE so the last run's value stays readable in IDLE.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni)                              iter_q <= '0;
      else if (state == ST_IDLE && start_i)     iter_q <= '0;
      else if (state == ST_WB_MOD && iter_q != 8'hFF) iter_q <= iter_q + 8'd1;
   end

   assign iter_o = iter_q;
   assign busy_o = (state != ST_IDLE);

   always_comb begin
      state_nxt               = state;
      done_o                  = 1'b0;
      error_o                 = 1'b0;
      alu_mode_o              = 3'd0;
      modulo_start_o          = 1'b0;
      zahl1_to_alu_a_o        = 1'b0;
      zahl2_to_alu_b_o        = 1'b0;
      wren_initial_o          = 1'b0;
      wren_zw_gross_o         = 1'b0;
      wren_zw_klein_o         = 1'b0;
      wren_zw_in_zahlen_o     = 1'b0;
      wren_erg_modulo_o       = 1'b0;
      wren_zahl_o             = 1'b0;
      wren_to_new_numbers_o   = 1'b0;
      check_for_termination_o = 1'b0;
      case (state)
         ST_IDLE:   if (start_i) state_nxt = ST_LOAD;
         ST_LOAD: begin
            wren_initial_o = 1'b1;
            state_nxt      = ST_MAX;
         end
         ST_MAX: begin
            alu_mode_o       = MODE_MAX;
            zahl1_to_alu_a_o = 1'b1;
            zahl2_to_alu_b_o = 1'b1;
            state_nxt        = ST_WB_MAX;
         end
         ST_WB_MAX: begin
            wren_zw_gross_o = 1'b1;
            state_nxt       = ST_MIN;
         end
         ST_MIN: begin
            alu_mode_o       = MODE_MIN;
            zahl1_to_alu_a_o = 1'b1;
            zahl2_to_alu_b_o = 1'b1;
            state_nxt        = ST_WB_MIN;
         end
         ST_WB_MIN: begin
            wren_zw_klein_o = 1'b1;
            state_nxt       = ST_SWAP;
         end
         ST_SWAP: begin
            wren_zw_in_zahlen_o = 1'b1;
            state_nxt           = ST_MOD_START;
         end
         ST_MOD_START: begin
            alu_mode_o       = MODE_MOD;
            zahl1_to_alu_a_o = 1'b1;
            zahl2_to_alu_b_o = 1'b1;
            modulo_start_o   = 1'b1;
            state_nxt        = ST_MOD_WAIT;
         end
         ST_MOD_WAIT: begin
            alu_mode_o       = MODE_MOD;
            zahl1_to_alu_a_o = 1'b1;
            zahl2_to_alu_b_o = 1'b1;
            if (modulo_ready_i)    state_nxt = ST_MOD_CAP;
`ifdef GCD_CTRL_TIMEOUT_EN
            else if (wait_expired) state_nxt = ST_ERROR;
`endif
         end
         // Operands stay selected one more cycle so the ALU output register captures the remainder.
         ST_MOD_CAP: begin
            alu_mode_o       = MODE_MOD;
            zahl1_to_alu_a_o = 1'b1;
            zahl2_to_alu_b_o = 1'b1;
            state_nxt        = ST_WB_MOD;
         end
         ST_WB_MOD: begin
            wren_erg_modulo_o = 1'b1;
            state_nxt         = ST_CHECK;
         end
         ST_CHECK: begin
            check_for_termination_o = 1'b1;
            state_nxt               = valid_i ? ST_DONE : ST_NEXT;
         end
         ST_NEXT: begin
            wren_zahl_o           = 1'b1;
            wren_to_new_numbers_o = 1'b1;
            state_nxt             = ST_MOD_START;
         end
         ST_DONE: begin
            done_o    = 1'b1;
            state_nxt = ST_IDLE;
         end
`ifdef GCD_CTRL_TIMEOUT_EN
         ST_ERROR: begin
            error_o   = 1'b1;
            state_nxt = ST_IDLE;
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_gcd_control.sv
// Directed bench for gcd_control with a small behavioural GCD datapath model
// reacting to the controller's selects and write enables.
module tb_gcd_control;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic       start_i = 1'b0;
   logic       valid_i = 1'b0;
   logic       modulo_ready_i = 1'b0;
   logic       busy_o, done_o, error_o;
   logic [7:0] iter_o;
   logic [2:0] alu_mode_o;
   logic       modulo_start_o, zahl1_to_alu_a_o, zahl2_to_alu_b_o;
   logic       wren_initial_o, wren_zw_gross_o, wren_zw_klein_o, wren_zw_in_zahlen_o;
   logic       wren_erg_modulo_o, wren_zahl_o, wren_to_new_numbers_o, check_for_termination_o;

   int checks = 0;
   int failures = 0;

   // datapath model state
   int  op1, op2, wcfg;
   bit  hold_ready = 1'b0;
   int  za, zb, alu_reg, gross, klein, erg, cnt, tmp;

   gcd_control dut (
      .clk                     (clk),
      .rst_ni                  (rst_ni),
      .start_i                 (start_i),
      .valid_i                 (valid_i),
      .modulo_ready_i          (modulo_ready_i),
      .busy_o                  (busy_o),
      .done_o                  (done_o),
      .error_o                 (error_o),
      .iter_o                  (iter_o),
      .alu_mode_o              (alu_mode_o),
      .modulo_start_o          (modulo_start_o),
      .zahl1_to_alu_a_o        (zahl1_to_alu_a_o),
      .zahl2_to_alu_b_o        (zahl2_to_alu_b_o),
      .wren_initial_o          (wren_initial_o),
      .wren_zw_gross_o         (wren_zw_gross_o),
      .wren_zw_klein_o         (wren_zw_klein_o),
      .wren_zw_in_zahlen_o     (wren_zw_in_zahlen_o),
      .wren_erg_modulo_o       (wren_erg_modulo_o),
      .wren_zahl_o             (wren_zahl_o),
      .wren_to_new_numbers_o   (wren_to_new_numbers_o),
      .check_for_termination_o (check_for_termination_o)
   );

   always #5 clk = ~clk;

   logic [24:0] all_out;
   assign all_out = {busy_o, done_o, error_o, iter_o, alu_mode_o, modulo_start_o,
                     zahl1_to_alu_a_o, zahl2_to_alu_b_o, wren_initial_o, wren_zw_gross_o,
                     wren_zw_klein_o, wren_zw_in_zahlen_o, wren_erg_modulo_o, wren_zahl_o,
                     wren_to_new_numbers_o, check_for_termination_o};

   // Datapath model: acts mid-cycle on the enables the controller presents this cycle.
   always @(negedge clk) begin
      if (!rst_ni) begin
         modulo_ready_i = 1'b0;
         valid_i = 1'b0;
         cnt = 0;
      end else begin
         valid_i = 1'b0;
         if (wren_initial_o) begin za = op1; zb = op2; end
         if (alu_mode_o == 3'd1 && zahl1_to_alu_a_o && zahl2_to_alu_b_o) alu_reg = (za > zb) ? za : zb;
         if (alu_mode_o == 3'd2 && zahl1_to_alu_a_o && zahl2_to_alu_b_o) alu_reg = (za < zb) ? za : zb;
         if (wren_zw_gross_o) gross = alu_reg;
         if (wren_zw_klein_o) klein = alu_reg;
         if (wren_zw_in_zahlen_o) begin za = gross; zb = klein; end
         if (modulo_start_o) begin
            cnt = wcfg;
            modulo_ready_i = (wcfg == 0) && !hold_ready;
         end else if (busy_o) begin
            if (cnt == 0) modulo_ready_i = !hold_ready;
            else cnt = cnt - 1;
         end
         if (wren_erg_modulo_o) erg = za % zb;
         if (check_for_termination_o) valid_i = (erg == 0);
         if (wren_zahl_o && wren_to_new_numbers_o) begin tmp = zb; zb = erg; za = tmp; end
      end
   end

   task automatic test_reset;
      #1;
      checks++;
      if (all_out !== 25'd0) begin
         failures++;
         $display("FAIL reset_state: got %h expected 0", all_out);
      end
      @(negedge clk); rst_ni = 1'b1;
   endtask

   task automatic run_gcd(input string name, input int a, input int b, input int w,
                          input int exp_res, input int exp_iter, input int exp_ms,
                          input int exp_done, input bit poke);
      int cyc, ms, dn, ndone, res;
      op1 = a; op2 = b; wcfg = w;
      @(posedge clk); #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      cyc = 1; ms = -1; dn = -1; ndone = 0; res = -1;
      while (busy_o && cyc < 400) begin
         if (modulo_start_o && ms < 0) ms = cyc;
         if (done_o) begin ndone++; dn = cyc; res = zb; end
         if (poke) start_i = (cyc == 10);
         @(posedge clk); #1;
         cyc++;
      end
      start_i = 1'b0;
      checks++;
      if (cyc >= 400) begin failures++; $display("FAIL %s_timeout: still busy after %0d cycles", name, cyc); end
      checks++;
      if (ms !== exp_ms) begin failures++; $display("FAIL %s_first_mod_start: got cycle %0d expected %0d", name, ms, exp_ms); end
      checks++;
      if (dn !== exp_done) begin failures++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, dn, exp_done); end
      checks++;
      if (ndone !== 1) begin failures++; $display("FAIL %s_done_count: got %0d expected 1", name, ndone); end
      checks++;
      if (res !== exp_res) begin failures++; $display("FAIL %s_result: got %0d expected %0d", name, res, exp_res); end
      checks++;
      if (iter_o !== 8'(exp_iter)) begin failures++; $display("FAIL %s_iter: got %0d expected %0d", name, iter_o, exp_iter); end
      checks++;
      if ({busy_o, done_o} !== 2'b00) begin failures++; $display("FAIL %s_idle_after: busy/done got %b expected 00", name, {busy_o, done_o}); end
   endtask

   task automatic test_reset_mid_run;
      int guard;
      op1 = 48; op2 = 18; wcfg = 0; hold_ready = 1'b0;
      @(posedge clk); #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      guard = 0;
      while (iter_o != 8'd1 && guard < 50) begin @(posedge clk); #1; guard++; end
      hold_ready = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      checks++;
      if ({busy_o, alu_mode_o, modulo_start_o, iter_o} !== {1'b1, 3'd3, 1'b0, 8'd1}) begin
         failures++;
         $display("FAIL mid_pre_reset: busy/mode/mstart/iter got %b/%0d/%b/%0d expected 1/3/0/1",
                  busy_o, alu_mode_o, modulo_start_o, iter_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if (all_out !== 25'd0) begin failures++; $display("FAIL mid_reset_outputs: got %h expected 0", all_out); end
      @(negedge clk); rst_ni = 1'b1; hold_ready = 1'b0;
   endtask

   task automatic test_stalled_modulo;
      int cyc, err_cyc, ndone;
      op1 = 48; op2 = 18; wcfg = 0; hold_ready = 1'b1;
      @(posedge clk); #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      cyc = 1; err_cyc = -1; ndone = 0;
      while (cyc < 100) begin
         if (error_o && err_cyc < 0) err_cyc = cyc;
         if (done_o) ndone++;
         @(posedge clk); #1;
         cyc++;
      end
`ifdef GCD_CTRL_TIMEOUT_EN
      checks++;
      if (err_cyc !== 72) begin failures++; $display("FAIL watchdog_cycle: got %0d expected 72", err_cyc); end
      checks++;
      if ({busy_o, ndone} !== {1'b0, 32'd0}) begin failures++; $display("FAIL watchdog_idle: busy %b dones %0d expected 0/0", busy_o, ndone); end
`else
      checks++;
      if ({busy_o, alu_mode_o, err_cyc, ndone} !== {1'b1, 3'd3, -32'sd1, 32'd0}) begin
         failures++;
         $display("FAIL stall_wait: busy %b mode %0d err_cyc %0d dones %0d expected 1/3/-1/0",
                  busy_o, alu_mode_o, err_cyc, ndone);
      end
`endif
      rst_ni = 1'b0;
      @(negedge clk); rst_ni = 1'b1; hold_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      run_gcd("gcd_48_18", 48, 18, 1, 6, 3, 7, 27, 1'b0);
      run_gcd("gcd_18_48", 18, 48, 1, 6, 3, 7, 27, 1'b0);
      run_gcd("gcd_17_5",  17,  5, 0, 1, 3, 7, 24, 1'b0);
      run_gcd("gcd_12_8",  12,  8, 2, 4, 2, 7, 22, 1'b0);
      run_gcd("back_to_back", 48, 18, 1, 6, 3, 7, 27, 1'b1);
      test_reset_mid_run();
      run_gcd("after_reset", 17, 5, 0, 1, 3, 7, 24, 1'b0);
      test_stalled_modulo();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gcd_control.md
# gcd_control

Sequencing controller for the 16-bit Euclidean GCD engine; sits directly upstream of the GCD datapath and drives every write-back flag, register-transfer select, ALU mode and modulo handshake it consumes. It loads operands, orders them larger/smaller, then iterates remainder computation until the datapath reports a zero remainder. It returns a one-cycle completion pulse with an iteration count.

## Interface
- MODE_MAX, 3'd1, ALU mode code: result = max(a, b)
- MODE_MIN, 3'd2, ALU mode code: result = min(a, b)
- MODE_MOD, 3'd3, ALU mode code: multi-cycle a mod b
- TIMEOUT_CYCLES, 64, MOD_WAIT watchdog limit (only with GCD_CTRL_TIMEOUT_EN)
- clk  in  1  system clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  request; sampled in IDLE only
- valid_i  in  1  datapath termination flag (remainder == 0 while check asserted)
- modulo_ready_i  in  1  ALU modulo finished (level, held until next start)
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse, result valid on datapath ergebnis
- error_o  out  1  one-cycle pulse on watchdog abort (constant 0 without macro)
- iter_o  out  8  completed modulo iterations of current/last run, saturates at 255
- alu_mode_o  out  3  ALU operation select
- modulo_start_o  out  1  one-cycle modulo launch pulse
- zahl1_to_alu_a_o, zahl2_to_alu_b_o  out  1 each  operand selects
- wren_initial_o, wren_zw_gross_o, wren_zw_klein_o, wren_zw_in_zahlen_o, wren_erg_modulo_o, wren_zahl_o, wren_to_new_numbers_o  out  1 each  datapath write enables
- check_for_termination_o  out  1  qualifies valid_i

## Operation
- Moore FSM, all outputs decoded from registered state; outputs not listed for a state are 0, alu_mode_o = 0.
- IDLE: start_i=1 -> LOAD; iter counter cleared on that edge.
- LOAD: wren_initial_o -> MAX.
- MAX: alu_mode_o=MODE_MAX, both selects -> WB_MAX.
- WB_MAX: wren_zw_gross_o -> MIN.
- MIN: alu_mode_o=MODE_MIN, both selects -> WB_MIN.
- WB_MIN: wren_zw_klein_o -> SWAP.
- SWAP: wren_zw_in_zahlen_o -> MOD_START.
- MOD_START: alu_mode_o=MODE_MOD, both selects, modulo_start_o -> MOD_WAIT.
- MOD_WAIT: MODE_MOD and selects held; modulo_ready_i=1 -> MOD_CAP.
- MOD_CAP: MODE_MOD and selects held (ALU output register captures) -> WB_MOD.
- WB_MOD: wren_erg_modulo_o; iter += 1 (saturating) -> CHECK.
- CHECK: check_for_termination_o; valid_i=1 -> DONE, else NEXT.
- NEXT: wren_zahl_o and wren_to_new_numbers_o together -> MOD_START.
- DONE: done_o -> IDLE.
- start_i outside IDLE ignored; no queuing.
- Operand zero (smaller operand 0) is outside contract; controller never checks operand values.

## Timing
- Reset (async assert): state IDLE, all outputs 0, iter_o = 0; deassertion synchronous-release assumed by top level.
- Reset mid-run: immediate return to IDLE, outputs 0 in same cycle as rst_ni low.
- Operands must be stable at datapath inputs from the cycle start_i is high through LOAD.
- Fixed overhead: start -> first modulo_start_o = 7 cycles (start edge, LOAD, MAX, WB_MAX, MIN, WB_MIN, SWAP).
- Per iteration: MOD_START + W waits + MOD_CAP + WB_MOD + CHECK (+ NEXT if not final) = W + 5 (final) / W + 6.
- done_o fires the cycle after CHECK with valid_i=1; busy_o falls with the same edge that leaves DONE.
- modulo_ready_i high in the same cycle as entering MOD_WAIT is accepted (W = 0 possible).

## Configuration
- GCD_CTRL_TIMEOUT_EN defined: 8-bit wait counter cleared on MOD_START, counts in MOD_WAIT; reaching TIMEOUT_CYCLES without modulo_ready_i -> one cycle ERROR state (error_o=1, busy_o=1) -> IDLE; no done_o.
- Not defined: no counter, no ERROR state, error_o tied 0; MOD_WAIT waits indefinitely.

## Test plan
- Reset: rst_ni low during MOD_WAIT -> all outputs 0 immediately, busy_o=0, iter_o=0.
- GCD(48,18), ready 1 cycle after start -> iterations 48%18=12, 18%12=6, 12%6=0; iter_o=3, done_o one cycle, ergebnis 6.
- GCD(18,48) -> same as above (ordering via MAX/MIN), iter_o=3, result 6.
- GCD(17,5) with ready after 0 cycles -> 17%5=2,5%2=1,2%1=0; first modulo_start_o exactly 7 cycles after start, iter_o=3, result 1.
- start_i pulsed during busy -> no restart, single done_o.
- With GCD_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=64, modulo_ready_i held 0 -> error_o pulse after 64 MOD_WAIT cycles, no done_o, back in IDLE next cycle.
